// File: rtl/bcd_conv_arbiter_if.sv
// rtl/bcd_conv_arbiter_if.sv - requester and converter signal bundle for bcd_conv_arbiter
interface bcd_conv_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ*16-1:0] req_data;
   logic [NUM_REQ-1:0]    gnt;
   logic                  rsp_valid;
   logic [ID_W-1:0]       rsp_id;
   logic [15:0]           rsp_bcd;
   logic [1:0]            rsp_err;
   logic                  busy;
   logic                  conv_en;
   logic [15:0]           conv_data;
   logic                  conv_done;
   logic [15:0]           conv_bcd;

   modport slave (
      input  req, req_data, conv_done, conv_bcd,
      output gnt, rsp_valid, rsp_id, rsp_bcd, rsp_err, busy, conv_en, conv_data
   );

   modport master (
      output req, req_data, conv_done, conv_bcd,
      input  gnt, rsp_valid, rsp_id, rsp_bcd, rsp_err, busy, conv_en, conv_data
   );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// rtl/bcd_conv_arbiter.sv - round-robin sharing of one binary-to-BCD converter
module bcd_conv_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int MAX_VAL = 9999,
   parameter int TIMEOUT = 32
) (
   input logic               clk,
   input logic               rst_n,
   bcd_conv_arbiter_if.slave bus
);
   localparam int              WC_W    = $clog2(TIMEOUT + 1);
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);
   localparam logic [15:0]     MAX_V   = 16'(MAX_VAL);
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, CAPTURE, RESP} state_t;

   state_t              state, state_nxt;
   logic [ID_W-1:0]     ptr, lat_id, win, cand;
   logic                found, out_range;
   logic [15:0]         win_data;
   logic [WC_W-1:0]     wcnt;
   logic [NUM_REQ-1:0]  gnt_q;
   logic [15:0]         conv_data_q, rsp_bcd_q;
   logic [ID_W-1:0]     rsp_id_q;
   logic [1:0]          rsp_err_q;

   // First set request at or above ptr, wrapping around.
   always_comb begin
      found = 1'b0;
      win   = ptr;
      cand  = ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign win_data  = bus.req_data[16*win +: 16];
   assign out_range = win_data > MAX_V;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found) state_nxt = out_range ? RESP : LOAD;
         LOAD:    state_nxt = START;
         START:   state_nxt = WAIT;
         WAIT:    if (bus.conv_done)        state_nxt = CAPTURE;
                  else if (wcnt == WC_LAST) state_nxt = RESP;
         CAPTURE: state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.conv_en   = (state == START);
      bus.rsp_valid = (state == RESP);
      bus.busy      = (state != IDLE);
   end

   // Response fields only change on the edge entering RESP so they hold between answers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr         <= '0;
         lat_id      <= '0;
         wcnt        <= '0;
         gnt_q       <= '0;
         conv_data_q <= '0;
         rsp_id_q    <= '0;
         rsp_bcd_q   <= '0;
         rsp_err_q   <= '0;
      end else begin
         gnt_q <= '0;
         case (state)
            IDLE: if (found) begin
               lat_id <= win;
               gnt_q  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
               if (out_range) begin
                  rsp_id_q  <= win;
                  rsp_err_q <= 2'b01;
                  rsp_bcd_q <= '0;
               end else begin
                  conv_data_q <= win_data;
               end
            end
            START: wcnt <= '0;
            WAIT: begin
               wcnt <= wcnt + 1'b1;
               if (!bus.conv_done && wcnt == WC_LAST) begin
                  rsp_id_q  <= lat_id;
                  rsp_err_q <= 2'b10;
                  rsp_bcd_q <= '0;
               end
            end
            CAPTURE: begin
               rsp_id_q  <= lat_id;
               rsp_err_q <= 2'b00;
               rsp_bcd_q <= bus.conv_bcd;
            end
            RESP: ptr <= (lat_id == LAST_ID) ? '0 : lat_id + 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.conv_data = conv_data_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_bcd   = rsp_bcd_q;
   assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb/tb_bcd_conv_arbiter.sv - directed self-checking bench for bcd_conv_arbiter
module tb_bcd_conv_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail = 0;
   int   delay = 0;
   int   cnt = -1;
   logic stray = 1'b0;
   logic done_prev = 1'b0;
   logic hit;

   bcd_conv_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

   bcd_conv_arbiter #(.NUM_REQ(4), .ID_W(2), .MAX_VAL(9999), .TIMEOUT(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input logic [15:0] v);
      int x;
      x = int'(v);
      return {4'((x / 1000) % 10), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
   endfunction

   // Converter model: done 'delay' cycles after conv_en, output register one cycle later.
   always @(negedge clk) begin
      if (!rst_n) begin
         cnt = -1;
         done_prev = 1'b0;
         bus.conv_done = 1'b0;
         bus.conv_bcd = 16'h0;
      end else begin
         if (done_prev) bus.conv_bcd = to_bcd(bus.conv_data);
         hit = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) hit = 1'b1;
         end
         if (bus.conv_en && delay > 0) cnt = delay;
         bus.conv_done = hit | stray;
         done_prev = hit;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(input int start, output int cyc);
      cyc = -1;
      for (int i = start + 1; i < start + 200; i++) begin
         tick();
         if (bus.rsp_valid) begin
            cyc = i;
            return;
         end
      end
   endtask

   task automatic wait_gnt(output int n);
      n = -1;
      for (int i = 1; i < 100; i++) begin
         tick();
         if (bus.gnt != 4'b0) begin
            n = i;
            return;
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      bus.req = 4'b0;
      bus.req_data = '0;
      rst_n = 1'b0;
      tick();
      tick();
      n_checks++; if (bus.gnt !== 4'b0) begin n_fail++; $display("FAIL reset_gnt got %b want 0000", bus.gnt); end
      n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
      n_checks++; if ({bus.rsp_id, bus.rsp_bcd, bus.rsp_err} !== 20'h0) begin n_fail++; $display("FAIL reset_rsp got %h want 0", {bus.rsp_id, bus.rsp_bcd, bus.rsp_err}); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      n_checks++; if ({bus.conv_en, bus.conv_data} !== 17'h0) begin n_fail++; $display("FAIL reset_conv got %h want 0", {bus.conv_en, bus.conv_data}); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      int cyc;
      delay = 19;
      bus.req = 4'b0001;
      bus.req_data[15:0] = 16'd1234;
      tick();
      n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt got %b want 0001", bus.gnt); end
      n_checks++; if (bus.conv_data !== 16'd1234) begin n_fail++; $display("FAIL single_conv_data got %0d want 1234", bus.conv_data); end
      n_checks++; if (bus.conv_en !== 1'b0) begin n_fail++; $display("FAIL single_en_load got %b want 0", bus.conv_en); end
      bus.req = 4'b0;
      tick();
      n_checks++; if (bus.conv_en !== 1'b1) begin n_fail++; $display("FAIL single_en_start got %b want 1", bus.conv_en); end
      wait_rsp(2, cyc);
      n_checks++; if (cyc !== 23) begin n_fail++; $display("FAIL single_rsp_cycle got %0d want 23", cyc); end
      n_checks++; if ({bus.rsp_id, bus.rsp_bcd, bus.rsp_err} !== {2'd0, 16'h1234, 2'b00}) begin n_fail++; $display("FAIL single_rsp got id=%0d bcd=%h err=%b want 0 1234 00", bus.rsp_id, bus.rsp_bcd, bus.rsp_err); end
      tick();
      n_checks++; if ({bus.rsp_valid, bus.conv_data} !== {1'b0, 16'd1234}) begin n_fail++; $display("FAIL single_hold got v=%b data=%0d want 0 1234", bus.rsp_valid, bus.conv_data); end
   endtask

   task automatic test_range();
      int cyc;
      bus.req = 4'b0100;
      bus.req_data[47:32] = 16'd10000;
      tick();
      n_checks++; if ({bus.gnt, bus.rsp_valid, bus.rsp_err} !== {4'b0100, 1'b1, 2'b01}) begin n_fail++; $display("FAIL range_resp got gnt=%b v=%b err=%b want 0100 1 01", bus.gnt, bus.rsp_valid, bus.rsp_err); end
      n_checks++; if ({bus.rsp_id, bus.rsp_bcd} !== {2'd2, 16'h0}) begin n_fail++; $display("FAIL range_fields got id=%0d bcd=%h want 2 0000", bus.rsp_id, bus.rsp_bcd); end
      bus.req = 4'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if ({bus.conv_en, bus.conv_data} !== {1'b0, 16'd1234}) begin n_fail++; $display("FAIL range_no_conv got en=%b data=%0d want 0 1234", bus.conv_en, bus.conv_data); end
         tick();
      end
      delay = 5;
      bus.req = 4'b0100;
      bus.req_data[47:32] = 16'd9999;
      tick();
      n_checks++; if ({bus.gnt, bus.rsp_valid} !== {4'b0100, 1'b0}) begin n_fail++; $display("FAIL max_gnt got gnt=%b v=%b want 0100 0", bus.gnt, bus.rsp_valid); end
      bus.req = 4'b0;
      wait_rsp(1, cyc);
      n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL max_cycle got %0d want 9", cyc); end
      n_checks++; if ({bus.rsp_id, bus.rsp_bcd, bus.rsp_err} !== {2'd2, 16'h9999, 2'b00}) begin n_fail++; $display("FAIL max_rsp got id=%0d bcd=%h err=%b want 2 9999 00", bus.rsp_id, bus.rsp_bcd, bus.rsp_err); end
      tick();
   endtask

   task automatic test_round_robin();
      int order [9] = '{0, 1, 2, 3, 0, 2, 3, 0, 2};
      int n, cyc;
      logic [3:0] want_gnt;
      do_reset();
      delay = 3;
      bus.req_data = {16'd4, 16'd3, 16'd2, 16'd1};
      bus.req = 4'b1111;
      for (int k = 0; k < 9; k++) begin
         want_gnt = 4'b0001 << order[k];
         wait_gnt(n);
         n_checks++; if (bus.gnt !== want_gnt) begin n_fail++; $display("FAIL rr_gnt[%0d] got %b want %b", k, bus.gnt, want_gnt); end
         wait_rsp(0, cyc);
         n_checks++; if ({bus.rsp_id, bus.rsp_bcd} !== {2'(order[k]), 16'(order[k] + 1)}) begin n_fail++; $display("FAIL rr_rsp[%0d] got id=%0d bcd=%h want %0d %0d", k, bus.rsp_id, bus.rsp_bcd, order[k], order[k] + 1); end
         if (k == 4) bus.req = 4'b1101;
      end
      bus.req = 4'b0;
      tick();
   endtask

   task automatic test_timeout();
      int cyc;
      do_reset();
      delay = 0;
      bus.req = 4'b0010;
      bus.req_data[31:16] = 16'd42;
      tick();
      n_checks++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL to_gnt got %b want 0010", bus.gnt); end
      bus.req = 4'b0;
      wait_rsp(1, cyc);
      n_checks++; if (cyc !== 35) begin n_fail++; $display("FAIL to_cycle got %0d want 35", cyc); end
      n_checks++; if ({bus.rsp_id, bus.rsp_bcd, bus.rsp_err} !== {2'd1, 16'h0, 2'b10}) begin n_fail++; $display("FAIL to_rsp got id=%0d bcd=%h err=%b want 1 0000 10", bus.rsp_id, bus.rsp_bcd, bus.rsp_err); end
      tick();
      delay = 3;
      bus.req = 4'b0011;
      bus.req_data[15:0] = 16'd7;
      bus.req_data[31:16] = 16'd8;
      tick();
      n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL to_ptr_gnt got %b want 0001", bus.gnt); end
      bus.req = 4'b0;
      wait_rsp(1, cyc);
      tick();
      delay = 32;
      bus.req = 4'b0100;
      bus.req_data[47:32] = 16'd77;
      tick();
      bus.req = 4'b0;
      wait_rsp(1, cyc);
      n_checks++; if (cyc !== 36) begin n_fail++; $display("FAIL late_done_cycle got %0d want 36", cyc); end
      n_checks++; if ({bus.rsp_bcd, bus.rsp_err} !== {16'h0077, 2'b00}) begin n_fail++; $display("FAIL late_done_rsp got bcd=%h err=%b want 0077 00", bus.rsp_bcd, bus.rsp_err); end
      tick();
   endtask

   task automatic test_stray_reset();
      int cyc;
      stray = 1'b1;
      tick();
      stray = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if ({bus.rsp_valid, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL stray_done got v=%b busy=%b want 0 0", bus.rsp_valid, bus.busy); end
         tick();
      end
      delay = 0;
      bus.req = 4'b0001;
      bus.req_data[15:0] = 16'd5;
      tick();
      bus.req = 4'b0;
      for (int i = 0; i < 4; i++) tick();
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy got %b want 1", bus.busy); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
      n_checks++; if ({bus.gnt, bus.rsp_valid, bus.conv_en, bus.conv_data} !== 22'h0) begin n_fail++; $display("FAIL midrst_ctl got %h want 0", {bus.gnt, bus.rsp_valid, bus.conv_en, bus.conv_data}); end
      n_checks++; if ({bus.rsp_id, bus.rsp_bcd, bus.rsp_err} !== 20'h0) begin n_fail++; $display("FAIL midrst_rsp got %h want 0", {bus.rsp_id, bus.rsp_bcd, bus.rsp_err}); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      delay = 3;
      bus.req = 4'b1000;
      bus.req_data[63:48] = 16'd3;
      tick();
      n_checks++; if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL midrst_after_gnt got %b want 1000", bus.gnt); end
      bus.req = 4'b0;
      wait_rsp(1, cyc);
      n_checks++; if ({bus.rsp_id, bus.rsp_bcd, bus.rsp_err} !== {2'd3, 16'h0003, 2'b00}) begin n_fail++; $display("FAIL midrst_after_rsp got id=%0d bcd=%h err=%b want 3 0003 00", bus.rsp_id, bus.rsp_bcd, bus.rsp_err); end
      tick();
   endtask

   task automatic test_back_to_back();
      int n, cyc;
      delay = 3;
      bus.req = 4'b0010;
      bus.req_data[31:16] = 16'd0;
      wait_gnt(n);
      n_checks++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL b2b_gnt1 got %b want 0010", bus.gnt); end
      bus.req_data[31:16] = 16'hFFFF;
      wait_rsp(0, cyc);
      n_checks++; if ({bus.rsp_id, bus.rsp_bcd, bus.rsp_err} !== {2'd1, 16'h0000, 2'b00}) begin n_fail++; $display("FAIL b2b_rsp1 got id=%0d bcd=%h err=%b want 1 0000 00", bus.rsp_id, bus.rsp_bcd, bus.rsp_err); end
      wait_gnt(n);
      n_checks++; if (n !== 2) begin n_fail++; $display("FAIL b2b_gap got %0d want 2", n); end
      n_checks++; if ({bus.gnt, bus.rsp_valid, bus.rsp_err, bus.rsp_bcd} !== {4'b0010, 1'b1, 2'b01, 16'h0}) begin n_fail++; $display("FAIL b2b_rsp2 got gnt=%b v=%b err=%b bcd=%h want 0010 1 01 0000", bus.gnt, bus.rsp_valid, bus.rsp_err, bus.rsp_bcd); end
      bus.req = 4'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_range();
      test_round_robin();
      test_timeout();
      test_stray_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Round-robin arbiter and sequencer that shares one 16-bit binary-to-BCD converter among `NUM_REQ` requesters, such as display channels or UART formatters. Each requester submits a binary value. The block range-checks it, drives the converter's start/data pins with the setup it needs, waits for the done pulse with a watchdog, then returns the 4-digit packed BCD result tagged with the requester ID. It sits between the requesting logic and the single converter instance.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `ID_W`, default 2: width of the requester ID, equal to clog2(`NUM_REQ`).
- `MAX_VAL`, default 9999: largest value the converter represents in 4 BCD digits.
- `TIMEOUT`, default 32: maximum number of WAIT cycles before the request is aborted.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester request level.
- `req_data`  in  NUM_REQ*16  binary values; requester i uses bits [16i+15:16i].
- `gnt`  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
- `rsp_valid`  out  1  one-cycle result strobe.
- `rsp_id`  out  ID_W  ID of the requester being answered.
- `rsp_bcd`  out  16  packed BCD result {thousands, hundreds, tens, units}.
- `rsp_err`  out  2  result status: 00 ok, 01 out of range, 10 timeout.
- `busy`  out  1  high whenever the state is not IDLE.
- `conv_en`  out  1  converter start pulse.
- `conv_data`  out  16  converter binary input.
- `conv_done`  in  1  converter done pulse.
- `conv_bcd`  in  16  converter packed BCD output.

## Operation
Reset values: every output is 0, the state is IDLE, and the round-robin pointer `ptr` is 0.

States and transitions:
- **IDLE**
  - If any `req` bit is high, select the first set bit scanning from `ptr` upward, wrapping modulo NUM_REQ.
  - Latch the winner's ID and its 16-bit data.
  - If data > MAX_VAL, go to RESP with `rsp_err` = 01 and `rsp_bcd` = 0. The converter is not touched.
  - Otherwise go to LOAD.
- **LOAD**
  - `conv_data` is driven from the latched value.
  - Hold for exactly one cycle so the converter samples `conv_data` while idle, then go to START.
- **START**
  - `conv_en` = 1 for this single cycle; `conv_data` is unchanged. Go to WAIT.
- **WAIT**
  - The watchdog counter `wcnt` clears on entry and increments each cycle.
  - If `conv_done` = 1, go to CAPTURE. `conv_done` has priority over the timeout in the same cycle.
  - Otherwise, if `wcnt` = TIMEOUT-1, go to RESP with `rsp_err` = 10 and `rsp_bcd` = 0.
- **CAPTURE**
  - The converter's output register updates on the edge after its done pulse, so `conv_bcd` is valid in this cycle.
  - Register `conv_bcd` into `rsp_bcd`, set `rsp_err` = 00, and go to RESP.
- **RESP**
  - `rsp_valid` = 1 for this one cycle.
  - `ptr` <= (latched ID + 1) mod NUM_REQ, then go to IDLE.

Holding rules:
- `conv_data` holds its value from LOAD through WAIT and CAPTURE, and keeps that value in IDLE until the next LOAD.
- `rsp_id`, `rsp_bcd` and `rsp_err` are registered and hold until the next RESP.

Boundary conditions:
- `conv_done` arriving in any state other than WAIT is ignored.
- `req` bits that fall before a grant are simply not served; there is no latching of withdrawn requests.
- A requester that still holds `req` high when the block returns to IDLE is treated as a new request.
- Because `ptr` advances past the served ID, every continuously asserted requester is served within NUM_REQ transactions.
- Value exactly MAX_VAL is in range; MAX_VAL+1 is out of range.
- Reset asserted mid-transaction returns all outputs to their reset values immediately. The converter shares `rst_n`.

## Timing
Cycle 0 is the IDLE cycle in which `req` is sampled.
- `gnt` is registered and pulses in cycle 1, the first cycle of LOAD or RESP.
- Requesters hold `req` and `req_data` stable through cycle 0. They may change both from cycle 1 onward.
- Converted path:
  - LOAD is cycle 1 and `conv_en` is high in cycle 2.
  - If `conv_done` is high in cycle D, `rsp_valid` is high in cycle D+2.
- Out-of-range path: `gnt` and `rsp_valid` are both high in cycle 1.
- Timeout path: `rsp_valid` is high in cycle 3+TIMEOUT.
- Throughput: after RESP, the next IDLE cycle can accept a new request, so there is no dead cycle beyond IDLE itself.

## Test plan
- **Single conversion.** Drive req[0] with 1234, converter model answering `conv_done` 19 cycles after `conv_en`.
  - `gnt` = 0001 in cycle 1 and `conv_data` = 1234 in cycle 1; `conv_en` pulses in cycle 2.
  - `rsp_valid` fires in cycle 23 with `rsp_id` = 0, `rsp_bcd` = 16'h1234, `rsp_err` = 00.
- **Range check.** Drive req[2] with 10000.
  - `gnt` = 0100, `rsp_valid` and `rsp_err` = 01 in cycle 1; `rsp_bcd` = 0; `conv_en` is never asserted.
  - Repeat with 9999: it converts normally to 16'h9999.
- **Round-robin fairness.** Hold all four `req` bits high with data 1, 2, 3, 4.
  - Grant order is 0,1,2,3,0, with `rsp_bcd` = 0001, 0002, 0003, 0004.
  - Drop req[1] after its grant: the order continues 2,3,0,2.
- **Timeout.** Converter model never asserts `conv_done`.
  - `rsp_err` = 10 and `rsp_bcd` = 0 in cycle 3+TIMEOUT; `ptr` still advances.
  - Assert `conv_done` in the same cycle as `wcnt` = TIMEOUT-1: the block goes to CAPTURE and the result is ok.
- **Stray done and mid-operation reset.**
  - A `conv_done` pulse in IDLE produces no `rsp_valid`.
  - Assert `rst_n` = 0 during WAIT: all outputs go to 0 and `busy` goes to 0 asynchronously. After release, req[3] is granted first from `ptr` = 0 scanning.
- **Back-to-back.** Keep req[1] high for two transactions with data 0 and then 65535.
  - First: `rsp_bcd` = 0000 with ok status. Second: `rsp_err` = 01.
  - The second `gnt` comes exactly 2 cycles after the first `rsp_valid`.
